// File: rtl/multi_hit_priority_encoder.sv
// Sequential multi-hit priority encoder: scans a captured word SLICE_W bits per cycle
// and streams out the index of every set bit, optionally capped at max_hits results.
module multi_hit_priority_encoder #(
    parameter int unsigned DATA_LEN   = 20,
    parameter int unsigned RESULT_LEN = $clog2(DATA_LEN),
    parameter int unsigned SLICE_W    = 4,
    parameter int unsigned CNT_LEN    = $clog2(DATA_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dut_start,
    input  logic                  lsb_first,
    input  logic [CNT_LEN-1:0]    max_hits,
    input  logic [DATA_LEN-1:0]   data_in,
    output logic                  dut_ready,
    output logic [RESULT_LEN-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  dut_done,
    output logic                  zero_f,
    output logic [CNT_LEN-1:0]    hit_count
);

    localparam int unsigned NUM_WIN = (DATA_LEN + SLICE_W - 1) / SLICE_W;
    localparam int unsigned PTR_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_LEN-1:0]   shadow_q, shadow_d;
    logic                  lsb_q, lsb_d;
    logic [CNT_LEN-1:0]    max_q, max_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [RESULT_LEN-1:0] result_q, result_d;
    logic [CNT_LEN-1:0]    hit_count_q, hit_count_d;
    logic                  zero_f_q, zero_f_d;
    logic                  ready_q, valid_q, done_q;

    logic                  win_hit;
    logic [RESULT_LEN-1:0] win_idx;
    logic [CNT_LEN-1:0]    cnt_inc;
    int                    bit_pos;

    // Window search: first set bit in scan order; positions outside the word read as 0
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        bit_pos = 0;
        for (int j = 0; j < int'(SLICE_W); j++) begin
            if (lsb_q) begin
                bit_pos = int'(ptr_q) * int'(SLICE_W) + j;
            end else begin
                bit_pos = int'(DATA_LEN) - 1 - int'(ptr_q) * int'(SLICE_W) - j;
            end
            if (!win_hit && bit_pos >= 0 && bit_pos < int'(DATA_LEN)) begin
                if (shadow_q[RESULT_LEN'(bit_pos)]) begin
                    win_hit = 1'b1;
                    win_idx = RESULT_LEN'(bit_pos);
                end
            end
        end
    end

    assign cnt_inc = hit_count_q + CNT_LEN'(1);

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        lsb_d       = lsb_q;
        max_d       = max_q;
        ptr_d       = ptr_q;
        result_d    = result_q;
        hit_count_d = hit_count_q;
        zero_f_d    = zero_f_q;

        unique case (state_q)
            S_IDLE: begin
                if (dut_start) begin
                    shadow_d    = data_in;
                    lsb_d       = lsb_first;
                    max_d       = max_hits;
                    ptr_d       = '0;
                    result_d    = '0;
                    hit_count_d = '0;
                    zero_f_d    = 1'b0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (win_hit) begin
                    result_d          = win_idx;
                    shadow_d[win_idx] = 1'b0;
                    state_d           = S_EMIT;
                end else if (ptr_q == PTR_W'(NUM_WIN - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            S_EMIT: begin
                if (result_ready) begin
                    hit_count_d = cnt_inc;
                    if (max_q != '0 && cnt_inc == max_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                zero_f_d = (hit_count_q == '0);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; status flags are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            lsb_q       <= 1'b0;
            max_q       <= '0;
            ptr_q       <= '0;
            result_q    <= '0;
            hit_count_q <= '0;
            zero_f_q    <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            lsb_q       <= lsb_d;
            max_q       <= max_d;
            ptr_q       <= ptr_d;
            result_q    <= result_d;
            hit_count_q <= hit_count_d;
            zero_f_q    <= zero_f_d;
            ready_q     <= (state_d == S_IDLE);
            valid_q     <= (state_d == S_EMIT);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign dut_ready    = ready_q;
    assign result_valid = valid_q;
    assign dut_done     = done_q;
    assign result       = result_q;
    assign hit_count    = hit_count_q;
    assign zero_f       = zero_f_q;

endmodule
